// File: rtl/wb_retire_ctrl.sv
// wb_retire_ctrl: writeback-stage sequencer.
// Retires the instruction in the WB latch. Non-store instructions retire in
// the same cycle. A store is captured, then issued to the D-cache as one
// piece, or as two pieces when it spills across a page. The WB latch is held
// (o_stall) until the final piece is acknowledged.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_v, i_regWr1/2, i_segWr, i_flagWr, i_memWr   instruction valid / write flags
//   i_dr1/2, i_drSeg          destination register numbers
//   i_data1/2                 result data (i_data1 is also the store data)
//   i_PA1/2, i_size1/2        store piece addresses and sizes (bytes-1)
//   i_spill                   bit0: store is split into two pieces
//   i_eflags                  flag result
//   mem_ack                   D-cache accepted the current piece
//   o_stall                   hold WB latch
//   o_rf_we1/2, o_seg_we, o_flag_we, o_rf_wa1/2, o_seg_wa   write ports
//   o_mem_req/pa/size/data    store request
//   o_retire, o_retire_cnt    retire pulse and wrapping retire count
module wb_retire_ctrl #(
  parameter int DATA_W = 32,
  parameter int PA_W   = 15,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_v,
  input  logic              i_regWr1,
  input  logic              i_regWr2,
  input  logic              i_segWr,
  input  logic              i_flagWr,
  input  logic              i_memWr,
  input  logic [2:0]        i_dr1,
  input  logic [2:0]        i_dr2,
  input  logic [2:0]        i_drSeg,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [PA_W-1:0]   i_PA1,
  input  logic [PA_W-1:0]   i_PA2,
  input  logic [1:0]        i_size1,
  input  logic [1:0]        i_size2,
  input  logic [1:0]        i_spill,
  input  logic [5:0]        i_eflags,
  input  logic              mem_ack,
  output logic              o_stall,
  output logic              o_rf_we1,
  output logic              o_rf_we2,
  output logic              o_seg_we,
  output logic              o_flag_we,
  output logic [2:0]        o_rf_wa1,
  output logic [2:0]        o_rf_wa2,
  output logic [2:0]        o_seg_wa,
  output logic              o_mem_req,
  output logic [PA_W-1:0]   o_mem_pa,
  output logic [1:0]        o_mem_size,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_retire,
  output logic [CNT_W-1:0]  o_retire_cnt
);

  typedef enum logic [1:0] {IDLE, MW1, MW2} state_e;

  state_e              state_q, state_d;
  logic [PA_W-1:0]     pa1_q, pa2_q;
  logic [1:0]          size1_q, size2_q;
  logic [DATA_W-1:0]   data1_q;
  logic                spill_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                capture;
  logic                done;
  logic [2:0]          bytes1;
  logic [5:0]          shamt;

  // Data, flags and the reserved spill bit are consumed elsewhere in the pipe.
  logic unused_in;
  assign unused_in = ^{i_spill[1], i_data2, i_eflags};

  assign capture = (state_q == IDLE) && i_v && i_memWr;

  // Second piece carries the bytes left over after the first piece.
  // size1=3 shifts by 32, which drains the word to zero.
  assign bytes1 = {1'b0, size1_q} + 3'd1;
  assign shamt  = {bytes1, 3'b000};

  // State and captured store registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pa1_q   <= '0;
      pa2_q   <= '0;
      size1_q <= '0;
      size2_q <= '0;
      data1_q <= '0;
      spill_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        pa1_q   <= i_PA1;
        pa2_q   <= i_PA2;
        size1_q <= i_size1;
        size2_q <= i_size2;
        data1_q <= i_data1;
        spill_q <= i_spill[0];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_v && i_memWr) state_d = MW1;
      MW1:     if (mem_ack) state_d = spill_q ? MW2 : IDLE;
      MW2:     if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    done       = 1'b0;
    o_stall    = 1'b0;
    o_mem_req  = 1'b0;
    o_mem_pa   = '0;
    o_mem_size = '0;
    o_mem_data = '0;
    case (state_q)
      IDLE: begin
        if (i_v) begin
          if (i_memWr) o_stall = 1'b1;
          else         done    = 1'b1;
        end
      end
      MW1: begin
        o_mem_req  = 1'b1;
        o_mem_pa   = pa1_q;
        o_mem_size = size1_q;
        o_mem_data = data1_q;
        if (mem_ack && !spill_q) done    = 1'b1;
        else                     o_stall = 1'b1;
      end
      MW2: begin
        o_mem_req  = 1'b1;
        o_mem_pa   = pa2_q;
        o_mem_size = size2_q;
        o_mem_data = data1_q >> shamt;
        if (mem_ack) done    = 1'b1;
        else         o_stall = 1'b1;
      end
      default: ;
    endcase

    // A reset cycle aborts whatever is in flight: nothing retires or writes.
    o_retire  = done && !rst;
    o_rf_we1  = o_retire && i_v && i_regWr1;
    o_rf_we2  = o_retire && i_v && i_regWr2;
    o_seg_we  = o_retire && i_v && i_segWr;
    o_flag_we = o_retire && i_v && i_flagWr;
  end

  assign cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, o_retire};
  assign o_retire_cnt = cnt_q;
  assign o_rf_wa1     = i_dr1;
  assign o_rf_wa2     = i_dr2;
  assign o_seg_wa     = i_drSeg;

endmodule

// File: tb/tb_wb_retire_ctrl.sv
module tb_wb_retire_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_v, i_regWr1, i_regWr2, i_segWr, i_flagWr, i_memWr;
  logic [2:0]  i_dr1, i_dr2, i_drSeg;
  logic [31:0] i_data1, i_data2;
  logic [14:0] i_PA1, i_PA2;
  logic [1:0]  i_size1, i_size2, i_spill;
  logic [5:0]  i_eflags;
  logic        mem_ack;
  logic        o_stall, o_rf_we1, o_rf_we2, o_seg_we, o_flag_we;
  logic [2:0]  o_rf_wa1, o_rf_wa2, o_seg_wa;
  logic        o_mem_req;
  logic [14:0] o_mem_pa;
  logic [1:0]  o_mem_size;
  logic [31:0] o_mem_data;
  logic        o_retire;
  logic [15:0] o_retire_cnt;

  always #5 clk = ~clk;

  wb_retire_ctrl #(.DATA_W(32), .PA_W(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .i_v(i_v), .i_regWr1(i_regWr1), .i_regWr2(i_regWr2),
    .i_segWr(i_segWr), .i_flagWr(i_flagWr), .i_memWr(i_memWr),
    .i_dr1(i_dr1), .i_dr2(i_dr2), .i_drSeg(i_drSeg),
    .i_data1(i_data1), .i_data2(i_data2), .i_PA1(i_PA1), .i_PA2(i_PA2),
    .i_size1(i_size1), .i_size2(i_size2), .i_spill(i_spill), .i_eflags(i_eflags),
    .mem_ack(mem_ack), .o_stall(o_stall), .o_rf_we1(o_rf_we1), .o_rf_we2(o_rf_we2),
    .o_seg_we(o_seg_we), .o_flag_we(o_flag_we), .o_rf_wa1(o_rf_wa1),
    .o_rf_wa2(o_rf_wa2), .o_seg_wa(o_seg_wa), .o_mem_req(o_mem_req),
    .o_mem_pa(o_mem_pa), .o_mem_size(o_mem_size), .o_mem_data(o_mem_data),
    .o_retire(o_retire), .o_retire_cnt(o_retire_cnt)
  );

  typedef struct packed {
    logic [63:0] tag;
    logic        stall, retire, req, we1, we2, sw, fw;
    logic [2:0]  wa1, wa2;
    logic [14:0] pa;
    logic [1:0]  sz;
    logic [31:0] d;
    logic [15:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_cnt;
  exp_t        me;
  logic        mok;

  function automatic exp_t E(input logic [63:0] tag, input logic st, rt, rq, w1, w2,
                             sw, fw, input logic [2:0] wa1, wa2, input logic [14:0] pa,
                             input logic [1:0] sz, input logic [31:0] d);
    exp_t e;
    e.tag = tag; e.stall = st; e.retire = rt; e.req = rq; e.we1 = w1; e.we2 = w2;
    e.sw = sw; e.fw = fw; e.wa1 = wa1; e.wa2 = wa2; e.pa = pa; e.sz = sz; e.d = d;
    e.cnt = '0;
    return e;
  endfunction

  // Queue the expected outputs for the cycle now being driven, then advance.
  task automatic step(input exp_t e);
    e.cnt = exp_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (e.retire) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic clr();
    i_v = 0; i_regWr1 = 0; i_regWr2 = 0; i_segWr = 0; i_flagWr = 0; i_memWr = 0;
    i_dr1 = 0; i_dr2 = 0; i_drSeg = 0; i_data1 = 0; i_data2 = 0;
    i_PA1 = 0; i_PA2 = 0; i_size1 = 0; i_size2 = 0; i_spill = 0; i_eflags = 0;
    mem_ack = 0;
  endtask

  // Monitor: one expected record per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      me = q.pop_front();
      tests++;
      mok = (o_stall === me.stall) && (o_retire === me.retire) && (o_mem_req === me.req) &&
            (o_rf_we1 === me.we1) && (o_rf_we2 === me.we2) && (o_seg_we === me.sw) &&
            (o_flag_we === me.fw) && (o_rf_wa1 === me.wa1) && (o_rf_wa2 === me.wa2) &&
            (o_retire_cnt === me.cnt);
      if (me.req)
        mok = mok && (o_mem_pa === me.pa) && (o_mem_size === me.sz) && (o_mem_data === me.d);
      if (!mok) begin
        fails++;
        $display("FAIL %s: got st=%b rt=%b rq=%b we1=%b we2=%b sw=%b fw=%b wa=%0d/%0d pa=%h sz=%0d d=%h cnt=%h | want st=%b rt=%b rq=%b we1=%b we2=%b sw=%b fw=%b wa=%0d/%0d pa=%h sz=%0d d=%h cnt=%h",
                 me.tag, o_stall, o_retire, o_mem_req, o_rf_we1, o_rf_we2, o_seg_we,
                 o_flag_we, o_rf_wa1, o_rf_wa2, o_mem_pa, o_mem_size, o_mem_data,
                 o_retire_cnt, me.stall, me.retire, me.req, me.we1, me.we2, me.sw, me.fw,
                 me.wa1, me.wa2, me.pa, me.sz, me.d, me.cnt);
      end
    end
  end

  initial begin
    clr();
    rst = 1;
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Reset state.
    step(E("rst", 0,0,0,0,0,0,0, 0,0, 0,0,0));

    // Back-to-back ALU retirements.
    i_v = 1; i_regWr1 = 1; i_dr1 = 3; i_segWr = 1; i_flagWr = 1; i_drSeg = 2;
    repeat (3) step(E("alu", 0,1,0,1,0,1,1, 3,0, 0,0,0));
    clr(); mem_ack = 1;
    step(E("ackidle", 0,0,0,0,0,0,0, 0,0, 0,0,0));
    mem_ack = 0;
    step(E("idle", 0,0,0,0,0,0,0, 0,0, 0,0,0));

    // Non-spill store with two wait cycles.
    i_v = 1; i_memWr = 1; i_regWr1 = 1; i_dr1 = 5;
    i_PA1 = 15'h1234; i_size1 = 3; i_data1 = 32'hDEADBEEF;
    step(E("st_ent", 1,0,0,0,0,0,0, 5,0, 0,0,0));
    step(E("st_w1",  1,0,1,0,0,0,0, 5,0, 15'h1234,3,32'hDEADBEEF));
    step(E("st_w2",  1,0,1,0,0,0,0, 5,0, 15'h1234,3,32'hDEADBEEF));
    mem_ack = 1;
    step(E("st_ret", 0,1,1,1,0,0,0, 5,0, 15'h1234,3,32'hDEADBEEF));
    clr();
    step(E("idle2", 0,0,0,0,0,0,0, 0,0, 0,0,0));

    // Spill store; live inputs change mid-flight and must not matter.
    i_v = 1; i_memWr = 1; i_PA1 = 15'h0FFF; i_size1 = 1; i_data1 = 32'hAABBCCDD;
    i_PA2 = 15'h2000; i_size2 = 1; i_spill = 2'b11; mem_ack = 1;
    step(E("sp_ent", 1,0,0,0,0,0,0, 0,0, 0,0,0));
    i_PA1 = 15'h5555; i_data1 = 32'h11111111; i_size1 = 3; i_spill = 0;
    step(E("sp_p1",  1,0,1,0,0,0,0, 0,0, 15'h0FFF,1,32'hAABBCCDD));
    step(E("sp_p2",  0,1,1,0,0,0,0, 0,0, 15'h2000,1,32'h0000AABB));

    // Spill with size1=3: second piece data drains to zero; we2/flag only at retire.
    clr();
    i_v = 1; i_memWr = 1; i_regWr2 = 1; i_dr2 = 6; i_flagWr = 1;
    i_PA1 = 15'h0100; i_size1 = 3; i_data1 = 32'h12345678;
    i_PA2 = 15'h0104; i_size2 = 0; i_spill = 2'b01; mem_ack = 1;
    step(E("s4_ent", 1,0,0,0,0,0,0, 0,6, 0,0,0));
    step(E("s4_p1",  1,0,1,0,0,0,0, 0,6, 15'h0100,3,32'h12345678));
    step(E("s4_p2",  0,1,1,0,1,0,1, 0,6, 15'h0104,0,32'h00000000));

    // Reserved spill bit alone does not split the store.
    clr();
    i_v = 1; i_memWr = 1; i_PA1 = 15'h0042; i_size1 = 0; i_data1 = 32'hCAFEF00D;
    i_spill = 2'b10; mem_ack = 1;
    step(E("nb_ent", 1,0,0,0,0,0,0, 0,0, 0,0,0));
    step(E("nb_ret", 0,1,1,0,0,0,0, 0,0, 15'h0042,0,32'hCAFEF00D));

    // Reset while waiting in MW2.
    clr();
    i_v = 1; i_memWr = 1; i_regWr1 = 1; i_dr1 = 1;
    i_PA1 = 15'h0300; i_size1 = 0; i_data1 = 32'h0000ABCD;
    i_PA2 = 15'h0301; i_size2 = 2; i_spill = 2'b01; mem_ack = 1;
    step(E("r_ent", 1,0,0,0,0,0,0, 1,0, 0,0,0));
    step(E("r_p1",  1,0,1,0,0,0,0, 1,0, 15'h0300,0,32'h0000ABCD));
    mem_ack = 0; rst = 1;
    step(E("r_p2",  1,0,1,0,0,0,0, 1,0, 15'h0301,2,32'h000000AB));
    exp_cnt = 0;
    rst = 0; clr();
    step(E("r_post", 0,0,0,0,0,0,0, 0,0, 0,0,0));

    // Counter wrap: 0xFFFF retirements, then one more.
    i_v = 1;
    repeat (16'hFFFF) step(E("pre", 0,1,0,0,0,0,0, 0,0, 0,0,0));
    step(E("wrap", 0,1,0,0,0,0,0, 0,0, 0,0,0));
    clr();
    step(E("wrap0", 0,0,0,0,0,0,0, 0,0, 0,0,0));

    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
